ram_ctrl: RTL

//  Request-side controller that sits directly upstream of the single-port RAM
//  (addr/data/cs/we in, dataOut registered on clk). Converts a valid/ready request

---
 rtl/ram_ctrl_if.sv | 26 ++
 rtl/ram_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ram_ctrl_if.sv
// Request/response channel between a client and ram_ctrl.
// The master drives requests and consumes responses; ram_ctrl is the slave.
interface ram_ctrl_if #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADDRWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATAWIDTH-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_ctrl.sv
// Request-side controller for a single-port RAM with registered strobes,
// one read in flight, and a full-array clear sweep after reset or on clr.
module ram_ctrl #(
    parameter int                   ADDRWIDTH  = 4,
    parameter int                   DATAWIDTH  = 8,
    parameter int                   SIZE       = 16,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    ram_ctrl_if.slave            bus,
    output logic                 init_done,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_data,
    output logic                 ram_cs,
    output logic                 ram_we,
    input  logic [DATAWIDTH-1:0] ram_dout
);
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        RSP
    } state_t;

    localparam logic [ADDRWIDTH:0]   SIZE_W = (ADDRWIDTH+1)'(SIZE);
    localparam logic [ADDRWIDTH-1:0] LAST   = ADDRWIDTH'(SIZE - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDRWIDTH-1:0] r_cnt;
    logic                 r_rd_err;
    logic [ADDRWIDTH-1:0] r_ram_addr;
    logic [DATAWIDTH-1:0] r_ram_data;
    logic                 r_ram_cs;
    logic                 r_ram_we;
    logic                 r_rsp_valid;
    logic [DATAWIDTH-1:0] r_rsp_rdata;
    logic                 r_rsp_err;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_in_range;

    assign w_ready    = (r_state == IDLE) && !clr;
    assign w_accept   = w_ready && bus.req_valid;
    assign w_in_range = ({1'b0, bus.req_addr} < SIZE_W);

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign init_done     = (r_state != INIT);
    assign ram_addr      = r_ram_addr;
    assign ram_data      = r_ram_data;
    assign ram_cs        = r_ram_cs;
    assign ram_we        = r_ram_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:     if (r_cnt == LAST) w_state_nxt = IDLE;
            IDLE: begin
                if (clr)                            w_state_nxt = INIT;
                else if (w_accept && !bus.req_we)   w_state_nxt = RD_ISSUE;
            end
            RD_ISSUE: w_state_nxt = RD_CAPT;
            RD_CAPT:  w_state_nxt = RSP;
            RSP:      if (bus.rsp_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rd_err    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_cs    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_ram_cs   <= 1'b1;
                    r_ram_we   <= 1'b1;
                    r_ram_addr <= r_cnt;
                    r_ram_data <= INIT_VALUE;
                    r_cnt      <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                end
                IDLE: begin
                    r_ram_cs <= 1'b0;
                    r_ram_we <= 1'b0;
                    if (clr) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        // Out-of-range requests never strobe the RAM
                        if (bus.req_we) begin
                            if (w_in_range) begin
                                r_ram_cs   <= 1'b1;
                                r_ram_we   <= 1'b1;
                                r_ram_addr <= bus.req_addr;
                                r_ram_data <= bus.req_wdata;
                            end
                        end else begin
                            r_ram_cs   <= w_in_range;
                            r_ram_addr <= bus.req_addr;
                            r_rd_err   <= !w_in_range;
                        end
                    end
                end
                RD_ISSUE: begin
                    r_ram_cs <= 1'b0;
                    r_ram_we <= 1'b0;
                end
                RD_CAPT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_rd_err ? '0 : ram_dout;
                    r_rsp_err   <= r_rd_err;
                end
                RSP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: begin
                    r_ram_cs <= 1'b0;
                    r_ram_we <= 1'b0;
                end
            endcase
        end
    end
endmodule
